// File: rtl/fxp_mac_pe.sv
// fxp_mac_pe: signed fixed-point multiply-accumulate processing element for the
// PCA covariance/projection systolic array. Operands and framing are forwarded
// east/south with one cycle of delay; the MAC itself is a two-stage pipeline
// (product register, then align + accumulate). All state updates on the falling
// clock edge to match the array timing.
module fxp_mac_pe #(
    parameter int DATA_W   = 8,
    parameter int FRAC_W   = 4,
    parameter int ACC_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_clear,
    input  logic              in_last,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_valid,
    output logic              out_clear,
    output logic              out_last,
    output logic [ACC_W-1:0]  out_sum,
    output logic              sum_valid,
    output logic              overflow
);

    localparam int PW = 2 * DATA_W;
    // Working width wide enough for both the full aligned product and acc + p,
    // so the range test below never loses the true sign.
    localparam int EW = ((ACC_W + 2) > (PW + 2)) ? (ACC_W + 2) : (PW + 2);

    localparam logic signed [EW-1:0] RND  = EW'((2 ** FRAC_W) / 2);
    localparam logic signed [EW-1:0] MAXV = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod_q;
    logic                 s1_valid;
    logic                 s1_clear;
    logic                 s1_last;
    logic                 last_q;

    logic signed [EW-1:0] prod_ext;
    logic signed [EW-1:0] rounded;
    logic signed [EW-1:0] p;
    logic signed [EW-1:0] acc_ext;
    logic signed [EW-1:0] total;
    logic                 term_ovf;
    logic [ACC_W-1:0]     next_acc;

    assign a_ext = {{DATA_W{in_a[DATA_W-1]}}, in_a};
    assign b_ext = {{DATA_W{in_b[DATA_W-1]}}, in_b};

    // Forward operands and framing to the neighbouring PEs, one cycle late.
    always_ff @(negedge clk) begin
        if (reset) begin
            out_a     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
            out_clear <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_clear <= in_valid & in_clear;
            out_last  <= in_valid & in_last;
            if (in_valid) begin
                out_a <= in_a;
                out_b <= in_b;
            end
        end
    end

    // Stage 1: register the full-width product and the term tags. The clear tag
    // travels even without valid so a bare clear can zero the accumulator.
    always_ff @(negedge clk) begin
        if (reset) begin
            prod_q   <= '0;
            s1_valid <= 1'b0;
            s1_clear <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            s1_clear <= in_clear;
            s1_last  <= in_valid & in_last;
            if (in_valid) begin
                prod_q <= a_ext * b_ext;
            end
        end
    end

    // Round-half-up alignment of the product, accumulate, and range check.
    always_comb begin
        prod_ext = {{(EW-PW){prod_q[PW-1]}}, prod_q};
        rounded  = prod_ext + RND;
        p        = rounded >>> FRAC_W;
        acc_ext  = {{(EW-ACC_W){out_sum[ACC_W-1]}}, out_sum};
        total    = s1_clear ? p : (acc_ext + p);
        term_ovf = (total > MAXV) || (total < MINV);
        next_acc = total[ACC_W-1:0];
        if (SATURATE != 0) begin
            if (total > MAXV) begin
                next_acc = MAXV[ACC_W-1:0];
            end else if (total < MINV) begin
                next_acc = MINV[ACC_W-1:0];
            end
        end
    end

    // Stage 2: update accumulator and sticky overflow; sum_valid follows the
    // stage-2 update of a last-tagged term by one further edge.
    always_ff @(negedge clk) begin
        if (reset) begin
            out_sum   <= '0;
            overflow  <= 1'b0;
            last_q    <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            last_q    <= s1_last;
            sum_valid <= last_q;
            if (s1_valid) begin
                out_sum  <= next_acc;
                overflow <= s1_clear ? term_ovf : (overflow | term_ovf);
            end else if (s1_clear) begin
                out_sum  <= '0;
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fxp_mac_pe.sv
// Directed-vector bench for fxp_mac_pe. Two instances share the stimulus: one
// saturating, one wrapping. Inputs change and outputs are sampled on the rising
// edge; the design updates on the falling edge.
module tb_fxp_mac_pe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_clear;
    logic        in_last;

    logic [7:0]  out_a, out_b;
    logic        out_valid, out_clear, out_last;
    logic [15:0] out_sum;
    logic        sum_valid, overflow;

    logic [7:0]  w_out_a, w_out_b;
    logic        w_out_valid, w_out_clear, w_out_last;
    logic [15:0] w_out_sum;
    logic        w_sum_valid, w_overflow;

    int n_vec = 0;
    int n_err = 0;

    fxp_mac_pe #(.DATA_W(8), .FRAC_W(4), .ACC_W(16), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_clear(in_clear), .in_last(in_last),
        .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_clear(out_clear),
        .out_last(out_last), .out_sum(out_sum), .sum_valid(sum_valid), .overflow(overflow)
    );

    fxp_mac_pe #(.DATA_W(8), .FRAC_W(4), .ACC_W(16), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_clear(in_clear), .in_last(in_last),
        .out_a(w_out_a), .out_b(w_out_b), .out_valid(w_out_valid), .out_clear(w_out_clear),
        .out_last(w_out_last), .out_sum(w_out_sum), .sum_valid(w_sum_valid), .overflow(w_overflow)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic l);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_clear = c;
        in_last  = l;
    endtask

    task automatic idle();
        put(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    // One falling (active) edge happens between consecutive rising edges.
    task automatic step();
        @(posedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_sum", out_sum, 16'h0000);
        check("rst_sv", sum_valid, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_a", out_a, 8'h00);
        check("rst_valid", out_valid, 1'b0);

        // Basic latency: 1.5 * 2.0 = 3.0 -> 0x0030
        put(1'b1, 8'h18, 8'h20, 1'b1, 1'b1);
        step();
        check("lat_out_a", out_a, 8'h18);
        check("lat_out_b", out_b, 8'h20);
        check("lat_valid", out_valid, 1'b1);
        check("lat_clear", out_clear, 1'b1);
        check("lat_last", out_last, 1'b1);
        check("lat_sv_early", sum_valid, 1'b0);
        idle();
        step();
        check("lat_sum", out_sum, 16'h0030);
        check("lat_sv_notyet", sum_valid, 1'b0);
        check("lat_a_hold", out_a, 8'h18);
        check("lat_valid_drop", out_valid, 1'b0);
        step();
        check("lat_sv", sum_valid, 1'b1);
        check("lat_sum_hold", out_sum, 16'h0030);
        step();
        check("lat_sv_pulse", sum_valid, 1'b0);

        // Signed accumulate: 3.0 + (-1.0 * 2.0) = 1.0
        put(1'b1, 8'h18, 8'h20, 1'b1, 1'b0);
        step();
        put(1'b1, 8'hF0, 8'h20, 1'b0, 1'b1);
        step();
        check("sgn_first", out_sum, 16'h0030);
        idle();
        step();
        check("sgn_sum", out_sum, 16'h0010);
        step();
        check("sgn_sv", sum_valid, 1'b1);
        check("sgn_ovf", overflow, 1'b0);
        step();

        // Rounding: 1*8 = 8, +8, >>4 = 1
        put(1'b1, 8'h01, 8'h08, 1'b1, 1'b1);
        step();
        idle();
        step();
        check("rnd_sum", out_sum, 16'h0001);
        step();

        // Saturation / wrap: 33 terms of 1008 each
        for (int i = 0; i < 33; i++) begin
            put(1'b1, 8'h7F, 8'h7F, (i == 0), (i == 32));
            step();
            if (i == 1) check("sat_first_term", out_sum, 16'd1008);
        end
        check("sat_32", out_sum, 16'h7E00);
        check("sat_32_ovf", overflow, 1'b0);
        check("wrap_32", w_out_sum, 16'h7E00);
        idle();
        step();
        check("sat_33", out_sum, 16'h7FFF);
        check("sat_33_ovf", overflow, 1'b1);
        check("wrap_33", w_out_sum, 16'h81F0);
        check("wrap_33_ovf", w_overflow, 1'b1);
        step();
        check("sat_sv", sum_valid, 1'b1);
        check("sat_ovf_sticky", overflow, 1'b1);
        step();
        step();
        check("sat_ovf_sticky2", overflow, 1'b1);
        check("sat_sum_hold", out_sum, 16'h7FFF);
        put(1'b1, 8'h10, 8'h10, 1'b1, 1'b1);
        step();
        idle();
        step();
        check("sat_clr_sum", out_sum, 16'h0010);
        check("sat_clr_ovf", overflow, 1'b0);
        check("wrap_clr_ovf", w_overflow, 1'b0);
        step();
        step();

        // Stall mid-frame, then back-to-back clear frame
        put(1'b1, 8'h10, 8'h10, 1'b1, 1'b0);
        step();
        idle();
        step();
        check("stl_first", out_sum, 16'h0010);
        check("stl_sv0", sum_valid, 1'b0);
        step();
        check("stl_sv1", sum_valid, 1'b0);
        step();
        check("stl_sv2", sum_valid, 1'b0);
        put(1'b1, 8'h10, 8'h10, 1'b0, 1'b1);
        step();
        check("stl_hold", out_sum, 16'h0010);
        put(1'b1, 8'h30, 8'h10, 1'b1, 1'b1);
        step();
        check("stl_sum", out_sum, 16'h0020);
        check("stl_sv_notyet", sum_valid, 1'b0);
        idle();
        step();
        check("b2b_sum", out_sum, 16'h0030);
        check("stl_sv", sum_valid, 1'b1);
        step();
        check("b2b_sv", sum_valid, 1'b1);
        check("b2b_sum_hold", out_sum, 16'h0030);
        step();
        check("b2b_sv_end", sum_valid, 1'b0);

        // Clear without valid zeroes acc two edges later, no forwarding, no pulse
        put(1'b0, 8'h55, 8'h66, 1'b1, 1'b0);
        step();
        check("bclr_fwd", out_clear, 1'b0);
        check("bclr_a_hold", out_a, 8'h30);
        check("bclr_sum_hold", out_sum, 16'h0030);
        idle();
        step();
        check("bclr_sum", out_sum, 16'h0000);
        step();
        check("bclr_sv", sum_valid, 1'b0);

        // Reset with two terms in flight
        put(1'b1, 8'h10, 8'h10, 1'b1, 1'b0);
        step();
        put(1'b1, 8'h20, 8'h10, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        check("mrst_sum", out_sum, 16'h0000);
        check("mrst_a", out_a, 8'h00);
        check("mrst_b", out_b, 8'h00);
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_last", out_last, 1'b0);
        check("mrst_sv", sum_valid, 1'b0);
        step();
        check("mrst_sum2", out_sum, 16'h0000);
        step();
        check("mrst_sv2", sum_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
